// File: rtl/uart_echo_responder_pkg.sv
// Shared definitions for the UART echo responder: frame-state encoding used by
// both the receive and transmit state machines, and a counter-width helper.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } frame_state_t;

   // Width of a counter that must reach clk_div-1 (at least one bit).
   function automatic int cnt_width(input int clk_div);
      return (clk_div > 1) ? $clog2(clk_div) : 1;
   endfunction

endpackage

// File: rtl/uart_echo_responder_fifo.sv
// Small synchronous FIFO holding received words until the transmitter takes them.
// Head word is presented directly from storage so a pop can load it the same cycle.
// A push while full is accepted only when a pop happens in the same cycle.
module uart_byte_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         push_data,
   output logic [WIDTH-1:0]         pop_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW:0]      count_reg;
   logic             do_push;
   logic             do_pop;

   assign full     = (count_reg == (AW+1)'(DEPTH));
   assign empty    = (count_reg == '0);
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign pop_data = mem[rd_ptr_reg];
   assign count    = count_reg;

   // Storage write; no reset needed on the data array.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   // Pointer and occupancy tracking; pointers wrap naturally (depth is a power of 2).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + (AW+1)'(1);
            2'b01:   count_reg <= count_reg - (AW+1)'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/uart_echo_responder.sv
// UART echo responder: receives frames on i_rx, queues good words, and
// re-transmits them on o_tx in arrival order. All outputs are registered.
module uart_echo_responder
   import uart_pkg::*;
#(
   parameter int p_CLK_DIV    = 10,
   parameter int p_WORD_LEN   = 8,
   parameter int p_FIFO_DEPTH = 4
) (
   input  logic                              i_clk,
   input  logic                              i_rst,
   input  logic                              i_rx,
   input  logic                              i_tx_en,
   output logic                              o_tx,
   output logic [p_WORD_LEN-1:0]             o_rx_data,
   output logic                              o_rx_valid,
   output logic                              o_frame_err,
   output logic                              o_overflow,
   output logic                              o_tx_active,
   output logic [$clog2(p_FIFO_DEPTH):0]     o_fifo_count
);

   localparam int CW = cnt_width(p_CLK_DIV);
   localparam int BW = $clog2(p_WORD_LEN);
   localparam logic [CW-1:0] DIV_LAST  = CW'(p_CLK_DIV - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(p_CLK_DIV / 2 - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(p_WORD_LEN - 1);

   logic [1:0] sync_reg;
   logic       rx_s;

   frame_state_t              rx_state_reg, rx_state_next;
   logic [CW-1:0]             rx_cnt_reg, rx_cnt_next;
   logic [BW-1:0]             rx_bit_reg, rx_bit_next;
   logic [p_WORD_LEN-1:0]     rx_shift_reg, rx_shift_next;
   logic [p_WORD_LEN-1:0]     rx_data_reg, rx_data_next;
   logic                      rx_valid_reg, rx_valid_next;
   logic                      frame_err_reg, frame_err_next;
   logic                      overflow_reg, overflow_next;
   logic                      rx_push;

   frame_state_t              tx_state_reg, tx_state_next;
   logic [CW-1:0]             tx_cnt_reg, tx_cnt_next;
   logic [BW-1:0]             tx_bit_reg, tx_bit_next;
   logic [p_WORD_LEN-1:0]     tx_shift_reg, tx_shift_next;
   logic                      tx_line_reg, tx_line_next;
   logic                      tx_active_reg, tx_active_next;
   logic                      tx_pop;

   logic [p_WORD_LEN-1:0]     fifo_data;
   logic                      fifo_full;
   logic                      fifo_empty;

   assign rx_s = sync_reg[1];

   // Two-flop synchroniser for the asynchronous serial input; idles high.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) sync_reg <= 2'b11;
      else       sync_reg <= {sync_reg[0], i_rx};
   end

   // Receive FSM next-state: half-bit start check, centre sampling, stop validation.
   always_comb begin
      rx_state_next  = rx_state_reg;
      rx_cnt_next    = rx_cnt_reg;
      rx_bit_next    = rx_bit_reg;
      rx_shift_next  = rx_shift_reg;
      rx_data_next   = rx_data_reg;
      rx_valid_next  = 1'b0;
      frame_err_next = 1'b0;
      overflow_next  = 1'b0;
      rx_push        = 1'b0;
      case (rx_state_reg)
         IDLE: begin
            if (!rx_s) begin
               rx_state_next = START;
               rx_cnt_next   = '0;
            end
         end
         START: begin
            if (rx_cnt_reg == HALF_LAST) begin
               rx_cnt_next   = '0;
               rx_bit_next   = '0;
               rx_state_next = rx_s ? IDLE : DATA;
            end else begin
               rx_cnt_next = rx_cnt_reg + CW'(1);
            end
         end
         DATA: begin
            if (rx_cnt_reg == DIV_LAST) begin
               rx_cnt_next   = '0;
               rx_shift_next = {rx_s, rx_shift_reg[p_WORD_LEN-1:1]};
               if (rx_bit_reg == BIT_LAST) rx_state_next = STOP;
               else                        rx_bit_next   = rx_bit_reg + BW'(1);
            end else begin
               rx_cnt_next = rx_cnt_reg + CW'(1);
            end
         end
         STOP: begin
            if (rx_cnt_reg == DIV_LAST) begin
               rx_cnt_next   = '0;
               rx_state_next = IDLE;
               if (rx_s) begin
                  rx_valid_next = 1'b1;
                  rx_data_next  = rx_shift_reg;
                  rx_push       = 1'b1;
                  overflow_next = fifo_full && !tx_pop;
               end else begin
                  frame_err_next = 1'b1;
               end
            end else begin
               rx_cnt_next = rx_cnt_reg + CW'(1);
            end
         end
         default: rx_state_next = IDLE;
      endcase
   end

   // Receive FSM state and output registers.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         rx_state_reg  <= IDLE;
         rx_cnt_reg    <= '0;
         rx_bit_reg    <= '0;
         rx_shift_reg  <= '0;
         rx_data_reg   <= '0;
         rx_valid_reg  <= 1'b0;
         frame_err_reg <= 1'b0;
         overflow_reg  <= 1'b0;
      end else begin
         rx_state_reg  <= rx_state_next;
         rx_cnt_reg    <= rx_cnt_next;
         rx_bit_reg    <= rx_bit_next;
         rx_shift_reg  <= rx_shift_next;
         rx_data_reg   <= rx_data_next;
         rx_valid_reg  <= rx_valid_next;
         frame_err_reg <= frame_err_next;
         overflow_reg  <= overflow_next;
      end
   end

   uart_byte_fifo #(
      .WIDTH (p_WORD_LEN),
      .DEPTH (p_FIFO_DEPTH)
   ) u_fifo (
      .clk       (i_clk),
      .rst       (i_rst),
      .push      (rx_push),
      .pop       (tx_pop),
      .push_data (rx_shift_reg),
      .pop_data  (fifo_data),
      .count     (o_fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Transmit FSM next-state: pop head when enabled, then start/data/stop bits.
   always_comb begin
      tx_state_next  = tx_state_reg;
      tx_cnt_next    = tx_cnt_reg;
      tx_bit_next    = tx_bit_reg;
      tx_shift_next  = tx_shift_reg;
      tx_line_next   = tx_line_reg;
      tx_active_next = tx_active_reg;
      tx_pop         = 1'b0;
      case (tx_state_reg)
         IDLE: begin
            if (!fifo_empty && i_tx_en) begin
               tx_pop         = 1'b1;
               tx_shift_next  = fifo_data;
               tx_cnt_next    = '0;
               tx_line_next   = 1'b0;
               tx_active_next = 1'b1;
               tx_state_next  = START;
            end
         end
         START: begin
            if (tx_cnt_reg == DIV_LAST) begin
               tx_cnt_next   = '0;
               tx_bit_next   = '0;
               tx_line_next  = tx_shift_reg[0];
               tx_state_next = DATA;
            end else begin
               tx_cnt_next = tx_cnt_reg + CW'(1);
            end
         end
         DATA: begin
            if (tx_cnt_reg == DIV_LAST) begin
               tx_cnt_next = '0;
               if (tx_bit_reg == BIT_LAST) begin
                  tx_line_next  = 1'b1;
                  tx_state_next = STOP;
               end else begin
                  tx_bit_next   = tx_bit_reg + BW'(1);
                  tx_line_next  = tx_shift_reg[1];
                  tx_shift_next = tx_shift_reg >> 1;
               end
            end else begin
               tx_cnt_next = tx_cnt_reg + CW'(1);
            end
         end
         STOP: begin
            if (tx_cnt_reg == DIV_LAST) begin
               tx_cnt_next    = '0;
               tx_active_next = 1'b0;
               tx_state_next  = IDLE;
            end else begin
               tx_cnt_next = tx_cnt_reg + CW'(1);
            end
         end
         default: tx_state_next = IDLE;
      endcase
   end

   // Transmit FSM state and line registers; reset forces the line idle immediately.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         tx_state_reg  <= IDLE;
         tx_cnt_reg    <= '0;
         tx_bit_reg    <= '0;
         tx_shift_reg  <= '0;
         tx_line_reg   <= 1'b1;
         tx_active_reg <= 1'b0;
      end else begin
         tx_state_reg  <= tx_state_next;
         tx_cnt_reg    <= tx_cnt_next;
         tx_bit_reg    <= tx_bit_next;
         tx_shift_reg  <= tx_shift_next;
         tx_line_reg   <= tx_line_next;
         tx_active_reg <= tx_active_next;
      end
   end

   assign o_tx        = tx_line_reg;
   assign o_tx_active = tx_active_reg;
   assign o_rx_data   = rx_data_reg;
   assign o_rx_valid  = rx_valid_reg;
   assign o_frame_err = frame_err_reg;
   assign o_overflow  = overflow_reg;

endmodule

// File: tb/tb_uart_echo_responder.sv
// Directed bench for uart_echo_responder: drives serial frames, counts output
// pulses, and decodes the echoed serial stream for comparison.
module tb_uart_echo_responder;

   logic       i_clk;
   logic       i_rst;
   logic       i_rx;
   logic       i_tx_en;
   logic       o_tx;
   logic [7:0] o_rx_data;
   logic       o_rx_valid;
   logic       o_frame_err;
   logic       o_overflow;
   logic       o_tx_active;
   logic [2:0] o_fifo_count;

   int n_chk = 0;
   int n_bad = 0;

   int         n_valid = 0;
   int         n_ferr  = 0;
   int         n_ovf   = 0;
   logic [7:0] last_rx = 8'h00;

   logic [7:0] tx_bytes [0:63];
   int         tx_n  = 0;
   int         tx_rd = 0;

   uart_echo_responder #(
      .p_CLK_DIV    (10),
      .p_WORD_LEN   (8),
      .p_FIFO_DEPTH (4)
   ) dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_rx         (i_rx),
      .i_tx_en      (i_tx_en),
      .o_tx         (o_tx),
      .o_rx_data    (o_rx_data),
      .o_rx_valid   (o_rx_valid),
      .o_frame_err  (o_frame_err),
      .o_overflow   (o_overflow),
      .o_tx_active  (o_tx_active),
      .o_fifo_count (o_fifo_count)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   // Drive one frame from a negedge: start, 8 data bits LSB first, chosen stop level.
   task automatic send_frame(input logic [7:0] d, input logic stop);
      i_rx = 1'b0;
      repeat (10) @(negedge i_clk);
      for (int i = 0; i < 8; i++) begin
         i_rx = d[i];
         repeat (10) @(negedge i_clk);
      end
      i_rx = stop;
      repeat (10) @(negedge i_clk);
      i_rx = 1'b1;
   endtask

   task automatic wait_tx(input int n, input int budget);
      int k;
      k = 0;
      while ((tx_n - tx_rd) < n && k < budget) begin
         @(negedge i_clk);
         k++;
      end
      chk("tx_wait", 32'((tx_n - tx_rd) >= n), 32'd1);
   endtask

   // Pulse monitor sampled on the falling edge.
   always @(negedge i_clk) begin
      if (o_rx_valid === 1'b1) begin
         n_valid++;
         last_rx = o_rx_data;
      end
      if (o_frame_err === 1'b1) n_ferr++;
      if (o_overflow === 1'b1)  n_ovf++;
   end

   // Serial decoder for o_tx: centre-samples each bit at the 10-clock period.
   always begin
      logic [7:0] b;
      @(negedge i_clk);
      if (o_tx === 1'b0) begin
         chk("tx_active_at_start", 32'(o_tx_active), 32'd1);
         repeat (4) @(negedge i_clk);
         chk("tx_start_bit", 32'(o_tx), 32'd0);
         for (int i = 0; i < 8; i++) begin
            repeat (10) @(negedge i_clk);
            b[i] = o_tx;
         end
         repeat (10) @(negedge i_clk);
         chk("tx_stop_bit", 32'(o_tx), 32'd1);
         tx_bytes[tx_n] = b;
         tx_n++;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int v0, f0, o0;
      i_rst   = 1'b1;
      i_rx    = 1'b1;
      i_tx_en = 1'b0;
      repeat (3) @(negedge i_clk);

      // Reset state
      chk("rst_tx",     32'(o_tx),         32'd1);
      chk("rst_active", 32'(o_tx_active),  32'd0);
      chk("rst_count",  32'(o_fifo_count), 32'd0);
      chk("rst_data",   32'(o_rx_data),    32'd0);
      chk("rst_valid",  32'(o_rx_valid),   32'd0);
      i_rst = 1'b0;
      repeat (5) @(negedge i_clk);

      // 1: single byte echo
      i_tx_en = 1'b1;
      v0 = n_valid;
      send_frame(8'hEE, 1'b1);
      repeat (2) @(negedge i_clk);
      chk("t1_valid_cnt", 32'(n_valid - v0), 32'd1);
      chk("t1_rx_data",   32'(last_rx),      32'hEE);
      wait_tx(1, 300);
      chk("t1_echo", 32'(tx_bytes[tx_rd]), 32'hEE);
      tx_rd++;
      repeat (20) @(negedge i_clk);

      // 2: framing error
      v0 = n_valid;
      f0 = n_ferr;
      send_frame(8'h55, 1'b0);
      repeat (30) @(negedge i_clk);
      chk("t2_ferr_cnt",  32'(n_ferr - f0),   32'd1);
      chk("t2_valid_cnt", 32'(n_valid - v0),  32'd0);
      chk("t2_count",     32'(o_fifo_count),  32'd0);
      chk("t2_no_echo",   32'(tx_n - tx_rd),  32'd0);
      chk("t2_tx_idle",   32'(o_tx),          32'd1);

      // 3: glitch then normal byte
      v0 = n_valid;
      f0 = n_ferr;
      i_rx = 1'b0;
      repeat (3) @(negedge i_clk);
      i_rx = 1'b1;
      repeat (30) @(negedge i_clk);
      chk("t3_glitch_valid", 32'(n_valid - v0), 32'd0);
      chk("t3_glitch_ferr",  32'(n_ferr - f0),  32'd0);
      send_frame(8'hA3, 1'b1);
      repeat (2) @(negedge i_clk);
      chk("t3_rx_data", 32'(last_rx), 32'hA3);
      wait_tx(1, 300);
      chk("t3_echo", 32'(tx_bytes[tx_rd]), 32'hA3);
      tx_rd++;
      repeat (20) @(negedge i_clk);

      // 4: fill FIFO, overflow on the fifth word, then drain in order
      i_tx_en = 1'b0;
      v0 = n_valid;
      o0 = n_ovf;
      for (int k = 0; k < 4; k++) send_frame(8'(k + 1), 1'b1);
      repeat (2) @(negedge i_clk);
      chk("t4_count_full", 32'(o_fifo_count), 32'd4);
      chk("t4_no_ovf_yet", 32'(n_ovf - o0),   32'd0);
      send_frame(8'h05, 1'b1);
      repeat (2) @(negedge i_clk);
      chk("t4_ovf_cnt",   32'(n_ovf - o0),    32'd1);
      chk("t4_valid_cnt", 32'(n_valid - v0),  32'd5);
      chk("t4_rx_data",   32'(last_rx),       32'h05);
      chk("t4_count_hold",32'(o_fifo_count),  32'd4);
      chk("t4_no_echo",   32'(tx_n - tx_rd),  32'd0);
      i_tx_en = 1'b1;
      wait_tx(4, 800);
      for (int k = 0; k < 4; k++) begin
         chk("t4_echo", 32'(tx_bytes[tx_rd]), 32'(k + 1));
         tx_rd++;
      end
      repeat (20) @(negedge i_clk);
      chk("t4_count_empty", 32'(o_fifo_count), 32'd0);

      // 5: back-to-back frames
      v0 = n_valid;
      send_frame(8'h3C, 1'b1);
      send_frame(8'hC3, 1'b1);
      repeat (2) @(negedge i_clk);
      chk("t5_valid_cnt", 32'(n_valid - v0), 32'd2);
      chk("t5_rx_data",   32'(last_rx),      32'hC3);
      wait_tx(2, 500);
      chk("t5_echo0", 32'(tx_bytes[tx_rd]), 32'h3C);
      tx_rd++;
      chk("t5_echo1", 32'(tx_bytes[tx_rd]), 32'hC3);
      tx_rd++;
      repeat (20) @(negedge i_clk);

      // 6: reset during data bit 3 of an echo (0x52 has bit 3 low)
      send_frame(8'h52, 1'b1);
      begin
         int k;
         k = 0;
         while (o_tx_active !== 1'b1 && k < 200) begin
            @(negedge i_clk);
            k++;
         end
         chk("t6_tx_started", 32'(o_tx_active), 32'd1);
      end
      repeat (44) @(negedge i_clk);
      chk("t6_bit3_low", 32'(o_tx), 32'd0);
      #1 i_rst = 1'b1;
      #1;
      chk("t6_rst_tx",     32'(o_tx),         32'd1);
      chk("t6_rst_active", 32'(o_tx_active),  32'd0);
      chk("t6_rst_count",  32'(o_fifo_count), 32'd0);
      chk("t6_rst_data",   32'(o_rx_data),    32'd0);
      repeat (3) @(negedge i_clk);
      i_rst = 1'b0;
      repeat (150) @(negedge i_clk);
      tx_rd = tx_n;
      send_frame(8'h81, 1'b1);
      repeat (2) @(negedge i_clk);
      chk("t6_rx_data", 32'(last_rx), 32'h81);
      wait_tx(1, 300);
      chk("t6_echo", 32'(tx_bytes[tx_rd]), 32'h81);
      tx_rd++;
      repeat (20) @(negedge i_clk);
      chk("t6_count_end", 32'(o_fifo_count), 32'd0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
